alu_add_seq: RTL and testbench

//  Multi-cycle adder, the inverse companion of the ALU subtract unit: computes S = A + B

---
 rtl/alu_add_seq.sv | 132 +++++++++++++
 tb/tb_alu_add_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_add_seq.sv
// alu_add_seq: multi-cycle adder, S = A + B computed CHUNK bits per cycle.
// Flags follow the subtract unit's Sign semantics (unsigned carry / two's
// complement overflow). Optional carry-in port Cin when ALU_ADD_CIN_EN is
// defined; otherwise the carry into chunk 0 is zero.
module alu_add_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sign,
`ifdef ALU_ADD_CIN_EN
  input  logic             Cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Z,
  output logic             V,
  output logic             N
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NCHUNK - 1);
  localparam int unsigned MSB    = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             sign_r;
  logic             carry;
  logic [KW-1:0]    k;
  logic             cin_in;
  logic             last;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] s_upd;
  logic             z_calc;
  logic             v_calc;
  logic             n_calc;

`ifdef ALU_ADD_CIN_EN
  assign cin_in = Cin;
`else
  assign cin_in = 1'b0;
`endif

  assign last = (k == LAST_K);
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: start is only honoured in IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Current chunk add, merged result word and flags from the final chunk
  always_comb begin
    chunk_sum = {1'b0, a_r[k*CHUNK +: CHUNK]}
              + {1'b0, b_r[k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
    s_upd = S;
    s_upd[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    z_calc = (s_upd == '0);
    if (sign_r) begin
      v_calc = (a_r[MSB] == b_r[MSB]) && (s_upd[MSB] != a_r[MSB]);
      n_calc = s_upd[MSB] ^ v_calc;
    end else begin
      v_calc = chunk_sum[CHUNK];
      n_calc = 1'b0;
    end
  end

  // Operand latch, chunk sequencing and result/flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r    <= '0;
      b_r    <= '0;
      sign_r <= 1'b0;
      carry  <= 1'b0;
      k      <= '0;
      S      <= '0;
      Z      <= 1'b0;
      V      <= 1'b0;
      N      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r    <= A;
            b_r    <= B;
            sign_r <= Sign;
            carry  <= cin_in;
            k      <= '0;
          end
        end
        RUN: begin
          S     <= s_upd;
          carry <= chunk_sum[CHUNK];
          if (last) begin
            k <= '0;
            Z <= z_calc;
            V <= v_calc;
            N <= n_calc;
          end else begin
            k <= k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_add_seq.sv
// Self-checking bench for alu_add_seq: expected results are queued when an
// operation is started and compared whenever the DUT pulses done.
module tb_alu_add_seq;

  localparam int unsigned NCH = 4;

  typedef struct packed {
    logic [31:0] s;
    logic        z;
    logic        v;
    logic        n;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Sign = 1'b0;
  logic        Cin = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] S;
  logic        Z;
  logic        V;
  logic        N;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;

  alu_add_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .Sign  (Sign),
`ifdef ALU_ADD_CIN_EN
    .Cin   (Cin),
`endif
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Z     (Z),
    .V     (V),
    .N     (N)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sg, input logic ci);
    exp_t        r;
    logic [32:0] u;
    longint      ex;
    u  = {1'b0, a} + {1'b0, b} + {32'b0, ci};
    ex = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
    r.s = u[31:0];
    r.z = (u[31:0] == 32'h0);
    if (sg) begin
      r.v = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
      r.n = (ex < 0);
    end else begin
      r.v = u[32];
      r.n = 1'b0;
    end
    return r;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic eff_cin(input logic ci);
`ifdef ALU_ADD_CIN_EN
    return ci;
`else
    return 1'b0 & ci;
`endif
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest queued result
  always @(negedge clk) begin
    if (done) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_done: observed done=1 expected no pending op");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check32("sum_S", S, e.s);
        check1("flag_Z", Z, e.z);
        check1("flag_V", V, e.v);
        check1("flag_N", N, e.n);
      end
    end
  end

  // One full operation: latency/busy profile checked, operands scrambled while busy;
  // poke=1 also holds start during the DONE cycle, which must be ignored.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic ci, input bit poke);
    A = a; B = b; Sign = sg; Cin = ci; start = 1'b1;
    sb.push_back(model(a, b, sg, eff_cin(ci)));
    tick();
    start = 1'b0;
    A = ~a; B = 32'h5A5A_5A5A; Sign = ~sg; Cin = ~ci;
    for (int c = 0; c < NCH; c++) begin
      check1("busy_run", busy, 1'b1);
      check1("done_run", done, 1'b0);
      tick();
    end
    check1("done_pulse", done, 1'b1);
    check1("busy_done", busy, 1'b0);
    if (poke) begin
      A = 32'h1; B = 32'h1; start = 1'b1;
    end
    tick();
    check1("done_clear", done, 1'b0);
    check1("busy_idle", busy, 1'b0);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    tick(); tick();
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check32("rst_S", S, 32'h0);
    check1("rst_Z", Z, 1'b0);
    check1("rst_V", V, 1'b0);
    check1("rst_N", N, 1'b0);
    reset = 1'b0;
    tick();

    // Basic add, unsigned carry-out, signed overflows, negative result
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 1'b1);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    run_op(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 1'b0);

    // Start while busy is ignored
    A = 32'h1234_5678; B = 32'h1111_1111; Sign = 1'b0; Cin = 1'b0; start = 1'b1;
    sb.push_back(model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0));
    tick();
    start = 1'b0;
    tick();
    A = '0; B = '0; start = 1'b1;
    tick();
    start = 1'b0;
    check1("busy_ignored_start", busy, 1'b1);
    tick(); tick();
    check1("done_ignored_start", done, 1'b1);
    tick(); tick(); tick();
    check1("no_second_op", busy, 1'b0);

    // Leave nonzero flags, then abort an op with reset in its 2nd RUN cycle
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; Sign = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);
    check32("abort_S", S, 32'h0);
    check1("abort_Z", Z, 1'b0);
    check1("abort_V", V, 1'b0);
    check1("abort_N", N, 1'b0);
    for (int c = 0; c < 8; c++) begin
      tick();
      check1("abort_no_done", done, 1'b0);
    end

    // Reset and start together: reset wins
    A = 32'h1; B = 32'h2; start = 1'b1; reset = 1'b1;
    tick();
    start = 1'b0; reset = 1'b0;
    check1("rst_start_busy", busy, 1'b0);
    tick();
    check1("rst_start_idle", busy, 1'b0);

    // Carry-in case (Cin ignored when the port is absent)
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1'b0);

    tick(); tick();
    check32("sb_empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
